// File: rtl/median_window_gen.sv
// median_window_gen: raster pixel stream -> 3x3 neighbourhood windows for a
// downstream median core. Two line buffers hold the previous two rows; a 3x3
// shift window takes one new column per accepted pixel. Only interior
// positions (row>=2, col>=2) emit a window, so stale buffer data never leaks.
// Optional macro MEDIAN_WIN_COORD_EN adds win_row_o/win_col_o (window centre).
module median_window_gen #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int PIX_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               sof_i,
  input  logic [PIX_W-1:0]   pix_i,
  input  logic               pix_valid_i,
  output logic               pix_ready_o,
  output logic [9*PIX_W-1:0] win_o,
  output logic               win_valid_o,
  input  logic               win_ready_i,
  output logic               frame_done_o
`ifdef MEDIAN_WIN_COORD_EN
  ,
  output logic [15:0]        win_row_o,
  output logic [15:0]        win_col_o
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  state_t            r_state;
  state_t            w_state_cur;
  state_t            w_state_next;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     w_col;
  logic [RW-1:0]     w_row;
  logic              w_accept;
  logic              w_last_col;
  logic              w_last_pix;
  logic              w_win_load;
  logic              r_win_valid;
  logic              r_frame_done;
  logic [PIX_W-1:0]  r_lb0 [IMG_W];
  logic [PIX_W-1:0]  r_lb1 [IMG_W];
  logic [PIX_W-1:0]  w_col_data [3];

  assign pix_ready_o  = !r_win_valid || win_ready_i;
  assign w_accept     = pix_valid_i && pix_ready_o;
  // A start-of-frame pixel is placed at (0,0) regardless of the old counters.
  assign w_col        = sof_i ? '0 : r_col;
  assign w_row        = sof_i ? '0 : r_row;
  assign w_state_cur  = sof_i ? IDLE : r_state;
  assign w_last_col   = (w_col == LAST_COL);
  assign w_last_pix   = w_last_col && (w_row == LAST_ROW);

  assign win_valid_o  = r_win_valid;
  assign frame_done_o = r_frame_done;

  // Row/column position of the next pixel to be accepted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= (w_row == LAST_ROW) ? '0 : w_row + RW'(1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end else if (sof_i) begin
      r_col <= '0;
      r_row <= '0;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // FSM next state: IDLE until first pixel, PRIME for rows 0..1, STREAM after.
  always_comb begin
    w_state_next = w_state_cur;
    if (w_accept) begin
      case (w_state_cur)
        IDLE:    w_state_next = PRIME;
        PRIME:   if (w_last_col && (w_row == RW'(1))) w_state_next = STREAM;
        STREAM:  if (w_last_pix) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // FSM outputs: a window is produced only at interior positions.
  always_comb begin
    w_win_load = 1'b0;
    if (w_accept && (w_state_cur == STREAM) && (w_col >= CW'(2)))
      w_win_load = 1'b1;
  end

  // Line buffers: rotate the current column down one row on every accept.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_lb1[w_col] <= r_lb0[w_col];
      r_lb0[w_col] <= pix_i;
    end
  end

  assign w_col_data[0] = r_lb1[w_col];
  assign w_col_data[1] = r_lb0[w_col];
  assign w_col_data[2] = pix_i;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [PIX_W-1:0] r_tap [3];

      // Shift this window row left and append the new column's pixel.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          r_tap[0] <= '0;
          r_tap[1] <= '0;
          r_tap[2] <= '0;
        end else if (w_accept) begin
          r_tap[0] <= r_tap[1];
          r_tap[1] <= r_tap[2];
          r_tap[2] <= w_col_data[gi];
        end
      end

      assign win_o[(gi*3+0)*PIX_W +: PIX_W] = r_tap[0];
      assign win_o[(gi*3+1)*PIX_W +: PIX_W] = r_tap[1];
      assign win_o[(gi*3+2)*PIX_W +: PIX_W] = r_tap[2];
    end
  endgenerate

  // Output handshake: a new window wins over a same-cycle consume.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (w_win_load) begin
      r_win_valid  <= 1'b1;
      r_frame_done <= w_last_pix;
    end else if (win_ready_i) begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end
  end

`ifdef MEDIAN_WIN_COORD_EN
  // Window centre coordinates, captured alongside the window.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      win_row_o <= '0;
      win_col_o <= '0;
    end else if (w_win_load) begin
      win_row_o <= 16'(w_row) - 16'd1;
      win_col_o <= 16'(w_col) - 16'd1;
    end
  end
`else
  // No coordinate tap in this build.
`endif

endmodule

// File: tb/tb_median_window_gen.sv
// Directed bench for median_window_gen on a 4x4 image: full frames,
// backpressure, mid-frame reset, mid-frame sof and back-to-back frames.
module tb_median_window_gen;

  logic        CLK = 1'b0;
  logic        RST;
  logic        sof_i;
  logic [7:0]  pix_i;
  logic        pix_valid_i;
  logic        pix_ready_o;
  logic [71:0] win_o;
  logic        win_valid_o;
  logic        win_ready_i;
  logic        frame_done_o;
`ifdef MEDIAN_WIN_COORD_EN
  logic [15:0] win_row_o;
  logic [15:0] win_col_o;
`endif

  median_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut (
    .CLK(CLK), .RST(RST), .sof_i(sof_i), .pix_i(pix_i),
    .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .win_o(win_o), .win_valid_o(win_valid_o), .win_ready_i(win_ready_i),
    .frame_done_o(frame_done_o)
`ifdef MEDIAN_WIN_COORD_EN
    , .win_row_o(win_row_o), .win_col_o(win_col_o)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  w [9];
    logic        fd;
    logic [15:0] r;
    logic [15:0] c;
  } exp_t;

  exp_t tbl [4];
  int   checks = 0;
  int   errors = 0;

  logic [71:0] cap_w  [$];
  logic        cap_fd [$];
  logic [15:0] cap_r  [$];
  logic [15:0] cap_c  [$];

  // Record every window at the cycle it is consumed.
  always @(negedge CLK) begin
    if (RST && win_valid_o && win_ready_i) begin
      cap_w.push_back(win_o);
      cap_fd.push_back(frame_done_o);
`ifdef MEDIAN_WIN_COORD_EN
      cap_r.push_back(win_row_o);
      cap_c.push_back(win_col_o);
`else
      cap_r.push_back(16'd0);
      cap_c.push_back(16'd0);
`endif
    end
  end

  function automatic logic [71:0] pack(input exp_t e, input int off);
    logic [71:0] p;
    for (int k = 0; k < 9; k++) p[k*8 +: 8] = e.w[k] + 8'(off);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] p, input logic s);
    int n;
    n = 0;
    pix_i = p; sof_i = s; pix_valid_i = 1'b1;
    @(negedge CLK);
    while (!pix_ready_o && n < 200) begin
      n++;
      @(negedge CLK);
    end
    chk("send_ready", {71'd0, pix_ready_o}, 72'd1);
    @(posedge CLK); #1;
    pix_valid_i = 1'b0; sof_i = 1'b0;
  endtask

  task automatic check_frames(input string nm, input int nwin, input int off);
    int nfd;
    nfd = 0;
    chk({nm, "_count"}, 72'(cap_w.size()), 72'(nwin));
    for (int i = 0; i < cap_w.size() && i < nwin; i++) begin
      $display("%s win %0d: %h fd=%0d", nm, i, cap_w[i], cap_fd[i]);
      chk({nm, "_win"}, cap_w[i], pack(tbl[i % 4], off));
      chk({nm, "_fd"}, {71'd0, cap_fd[i]}, {71'd0, tbl[i % 4].fd});
      if (cap_fd[i]) nfd++;
`ifdef MEDIAN_WIN_COORD_EN
      chk({nm, "_row"}, 72'(cap_r[i]), 72'(tbl[i % 4].r));
      chk({nm, "_col"}, 72'(cap_c[i]), 72'(tbl[i % 4].c));
`endif
    end
    chk({nm, "_fd_pulses"}, 72'(nfd), 72'(nwin / 4));
    cap_w.delete(); cap_fd.delete(); cap_r.delete(); cap_c.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0].w = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    tbl[0].fd = 1'b0; tbl[0].r = 16'd1; tbl[0].c = 16'd1;
    tbl[1].w = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    tbl[1].fd = 1'b0; tbl[1].r = 16'd1; tbl[1].c = 16'd2;
    tbl[2].w = '{8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14};
    tbl[2].fd = 1'b0; tbl[2].r = 16'd2; tbl[2].c = 16'd1;
    tbl[3].w = '{8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    tbl[3].fd = 1'b1; tbl[3].r = 16'd2; tbl[3].c = 16'd2;

    RST = 1'b0; sof_i = 1'b0; pix_i = '0; pix_valid_i = 1'b0; win_ready_i = 1'b1;
    #3;
    chk("rst_valid", {71'd0, win_valid_o}, 72'd0);
    chk("rst_ready", {71'd0, pix_ready_o}, 72'd1);
    chk("rst_win", win_o, 72'd0);
    chk("rst_fd", {71'd0, frame_done_o}, 72'd0);
    @(posedge CLK); #1; RST = 1'b1;

    // Full frame with latency checks around the first window.
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0);
      if (i == 9)  chk("lat_before", {71'd0, win_valid_o}, 72'd0);
      if (i == 10) begin
        chk("lat_first", {71'd0, win_valid_o}, 72'd1);
        chk("lat_first_win", win_o, pack(tbl[0], 0));
      end
    end
    repeat (4) @(posedge CLK); #1;
    check_frames("frame", 4, 0);

    // Backpressure after the first window.
    for (int i = 0; i < 11; i++) send(8'(i), 1'b0);
    win_ready_i = 1'b0; pix_i = 8'd11; pix_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("bp_ready", {71'd0, pix_ready_o}, 72'd0);
      chk("bp_valid", {71'd0, win_valid_o}, 72'd1);
      chk("bp_win", win_o, pack(tbl[0], 0));
    end
    @(posedge CLK); #1; win_ready_i = 1'b1;
    for (int i = 11; i < 16; i++) send(8'(i), 1'b0);
    repeat (4) @(posedge CLK); #1;
    check_frames("bp", 4, 0);

    // Reset in the middle of a frame.
    for (int i = 0; i < 10; i++) send(8'(i), 1'b0);
    RST = 1'b0;
    #1;
    chk("mrst_valid", {71'd0, win_valid_o}, 72'd0);
    chk("mrst_ready", {71'd0, pix_ready_o}, 72'd1);
    repeat (2) @(posedge CLK); #1; RST = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    repeat (4) @(posedge CLK); #1;
    check_frames("mrst", 4, 0);

    // Start-of-frame in the middle of a frame.
    for (int i = 0; i < 7; i++) send(8'(i), 1'b0);
    send(8'd100, 1'b1);
    for (int i = 101; i < 116; i++) send(8'(i), 1'b0);
    repeat (4) @(posedge CLK); #1;
    check_frames("sof", 4, 100);

    // Two back-to-back frames.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    repeat (4) @(posedge CLK); #1;
    check_frames("b2b", 8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/median_window_gen.md
MEDIAN_WINDOW_GEN -- requirements
Module: median_window_gen

Interface
REQ-001 The block SHALL have parameter IMG_W, default 16, meaning pixels per image row (range 3..4096).
REQ-002 The block SHALL have parameter IMG_H, default 16, meaning rows per frame (range 3..4096).
REQ-003 The block SHALL have parameter PIX_W, default 8, meaning bits per pixel.
REQ-004 The block SHALL have port CLK, input, 1, the single clock; all logic runs on its rising edge.
REQ-005 The block SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port sof_i, input, 1, synchronous start-of-frame; it restarts the pixel counters.
REQ-007 The block SHALL have port pix_i, input, PIX_W, the raster-order input pixel.
REQ-008 The block SHALL have port pix_valid_i, input, 1, meaning pix_i is valid.
REQ-009 The block SHALL have port pix_ready_o, output, 1, meaning the block accepts pix_i this cycle.
REQ-010 The block SHALL have port win_o, output, 9*PIX_W, the 3x3 window; slot k sits at [k*PIX_W +: PIX_W], row-major, k=0 top-left, k=8 bottom-right (newest pixel).
REQ-011 The block SHALL have port win_valid_o, output, 1, meaning win_o holds a window.
REQ-012 The block SHALL have port win_ready_i, input, 1, meaning the downstream median core consumes win_o.
REQ-013 The block SHALL have port frame_done_o, output, 1, which is high with the last window of a frame.

Function
REQ-014 Input accept SHALL occur when pix_valid_i && pix_ready_o; pix_ready_o SHALL equal !win_valid_o || win_ready_i, combinationally.
REQ-015 The block SHALL keep two line buffers of IMG_W x PIX_W and a 3x3 register window; on each accept it SHALL shift the column registers left, load the new column {linebuf1[col], linebuf0[col], pix_i}, and write linebuf1[col]<=linebuf0[col] and linebuf0[col]<=pix_i.
REQ-016 Counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL advance on accept; col SHALL wrap to 0 with row+1, and row SHALL wrap to 0 after (IMG_H-1, IMG_W-1).
REQ-017 The FSM SHALL have three states: IDLE (after reset or sof_i), PRIME (row<2), STREAM (row>=2); IDLE->PRIME on the first accept, PRIME->STREAM when row becomes 2, STREAM->IDLE on the accept of the last pixel of the frame.
REQ-018 A window SHALL be emitted only for an accept with row>=2 and col>=2 (interior only), giving (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-019 Latency SHALL be one cycle: win_valid_o and win_o are registered on the cycle after the qualifying accept.
REQ-020 win_valid_o SHALL clear on win_ready_i unless a new window is loaded in the same cycle, and win_o SHALL stay stable while win_valid_o && !win_ready_i.
REQ-021 frame_done_o SHALL be asserted with the window of the accept at (IMG_H-1, IMG_W-1) and SHALL be held exactly as long as that window's win_valid_o.
REQ-022 sof_i SHALL reset row, col and the FSM to IDLE; if sof_i coincides with an accept, that pixel SHALL be taken as (0,0); a pending output window SHALL NOT be dropped.
REQ-023 Stale line-buffer or column contents SHALL never reach win_o, which REQ-018 guarantees; the buffers SHALL NOT need clearing.

Reset
REQ-024 While RST=0: win_valid_o=0, frame_done_o=0, win_o=0, row=col=0, FSM=IDLE, and pix_ready_o=1 (it is derived from win_valid_o); line buffer contents SHALL be don't-care.
REQ-025 A reset mid-frame SHALL discard the partial frame, and the first accept after reset SHALL be (0,0).

Configuration
REQ-026 The macro MEDIAN_WIN_COORD_EN SHALL control the coordinate outputs: when it is defined, the block SHALL add outputs win_row_o and win_col_o (16 bits each) giving the window centre (row-1, col-1) and registered with win_o; when it is undefined, those ports and their registers SHALL be absent and all other behaviour SHALL be identical.

Verification (IMG_W=4, IMG_H=4, PIX_W=8 unless stated)
REQ-027 Sending pixels 0..15 with win_ready_i=1 SHALL produce 4 windows; the first SHALL be {0,1,2,4,5,6,8,9,10}, one cycle after pixel 10, and the last SHALL be {5,6,7,9,10,11,13,14,15} with frame_done_o=1.
REQ-028 Holding win_ready_i=0 after the first window SHALL drop pix_ready_o to 0, keep win_o stable for 10 cycles, and produce no loss or duplication once win_ready_i rises.
REQ-029 Asserting RST=0 after pixel 9 and then sending pixels 0..15 SHALL produce exactly 4 windows, identical to REQ-027.
REQ-030 Asserting sof_i with pixel 100 after pixel 6 and then sending 101..115 SHALL produce a first window of {100,101,102,104,105,106,108,109,110}.
REQ-031 Sending two back-to-back frames SHALL produce 8 windows and two frame_done_o pulses.
REQ-032 With MEDIAN_WIN_COORD_EN defined, the REQ-027 windows SHALL carry (row,col) = (1,1), (1,2), (2,1), (2,2).
